// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the register bank and its address checker.
package ahb_pkg;

  // HTRANS transfer types
  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  // HSIZE codes supported by the bank (anything wider is an error)
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // HRESP codes
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // True for the transfer types that start a real address phase
  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == TRANS_NONSEQ) || (htrans == TRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_check.sv
// Address-phase decode: word offset, byte-lane strobe and error flag
// (region tag mismatch, unsupported size, or misaligned access).
module ahb_addr_check
  import ahb_pkg::*;
#(
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int          OffsetWidth = 6
) (
  input  logic [31:0]            HADDR,
  input  logic [2:0]             HSIZE,
  output logic [OffsetWidth-1:0] offset,
  output logic [3:0]             strobe,
  output logic                   err
);

  localparam int TagLsb = OffsetWidth + 2;

  logic tag_ok;
  logic size_err;

  assign offset = HADDR[TagLsb-1:2];
  assign tag_ok = (HADDR[31:TagLsb] == BaseAddr[31:TagLsb]);

  // Lane strobe and alignment/size legality from HSIZE and the low address bits
  always_comb begin
    strobe   = 4'b0000;
    size_err = 1'b0;
    case (HSIZE)
      HSIZE_BYTE: begin
        strobe = 4'b0001 << HADDR[1:0];
      end
      HSIZE_HALF: begin
        strobe   = HADDR[1] ? 4'b1100 : 4'b0011;
        size_err = HADDR[0];
      end
      HSIZE_WORD: begin
        strobe   = 4'b1111;
        size_err = |HADDR[1:0];
      end
      default: begin
        size_err = 1'b1;
      end
    endcase
  end

  assign err = !tag_ok || size_err;

endmodule

// File: rtl/ahb_reg_bank.sv
// AHB-Lite slave register bank: 2**OffsetWidth 32-bit words with byte-lane
// writes, optional wait states and a two-cycle ERROR response.
module ahb_reg_bank
  import ahb_pkg::*;
#(
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int          OffsetWidth = 6,
  parameter int          WaitStates  = 0
) (
  input  logic                              HCLK,
  input  logic                              HRESETn,
  input  logic                              HSEL,
  input  logic [31:0]                       HADDR,
  input  logic [1:0]                        HTRANS,
  input  logic                              HWRITE,
  input  logic [2:0]                        HSIZE,
  input  logic [31:0]                       HWDATA,
  input  logic                              HREADY,
  output logic                              HREADYOUT,
  output logic                              HRESP,
  output logic [31:0]                       HRDATA,
  output logic [32*(2**OffsetWidth)-1:0]    regs_o
);

  localparam int         NumWords = 2 ** OffsetWidth;
  localparam logic [3:0] WaitLoad = 4'(WaitStates > 0 ? WaitStates - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                      state_reg, state_next;
  logic [3:0]                  cnt_reg, cnt_next;
  logic                        dp_valid_reg;
  logic                        dp_write_reg;
  logic [OffsetWidth-1:0]      dp_off_reg;
  logic [3:0]                  dp_strb_reg;
  logic [NumWords-1:0][31:0]   mem_reg;

  logic [OffsetWidth-1:0]      ap_offset;
  logic [3:0]                  ap_strobe;
  logic                        ap_err;
  logic                        can_accept;
  logic                        accept;
  logic                        complete;

  ahb_addr_check #(
    .BaseAddr   (BaseAddr),
    .OffsetWidth(OffsetWidth)
  ) u_addr_check (
    .HADDR (HADDR),
    .HSIZE (HSIZE),
    .offset(ap_offset),
    .strobe(ap_strobe),
    .err   (ap_err)
  );

  // Only IDLE and ERR2 drive HREADYOUT high, so only they can end an address phase
  assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
  assign accept     = HSEL && is_active_trans(HTRANS) && HREADY && can_accept;
  // An OKAY data phase finishes in the first IDLE cycle after its accept
  assign complete   = dp_valid_reg && (state_reg == ST_IDLE);

  // State and wait counter registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and response outputs; ERR2 accepts new work exactly like IDLE
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    case (state_reg)
      ST_IDLE, ST_ERR2: begin
        if (state_reg == ST_ERR2) begin
          HRESP = HRESP_ERROR;
        end
        state_next = ST_IDLE;
        if (accept) begin
          if (ap_err) begin
            state_next = ST_ERR1;
          end else if (WaitStates > 0) begin
            state_next = ST_WAIT;
            cnt_next   = WaitLoad;
          end
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_reg == 4'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = HRESP_ERROR;
        state_next = ST_ERR2;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Capture the accepted address phase; erroring transfers never open a data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_off_reg   <= '0;
      dp_strb_reg  <= 4'b0000;
    end else if (accept) begin
      dp_valid_reg <= !ap_err;
      dp_write_reg <= HWRITE;
      dp_off_reg   <= ap_offset;
      dp_strb_reg  <= ap_strobe;
    end else if (complete) begin
      dp_valid_reg <= 1'b0;
    end
  end

  // Commit write data lane by lane at the completing edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mem_reg <= '0;
    end else if (complete && dp_write_reg) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (dp_strb_reg[lane]) begin
          mem_reg[dp_off_reg][8*lane +: 8] <= HWDATA[8*lane +: 8];
        end
      end
    end
  end

  // Read data is only driven during a completing read data phase
  assign HRDATA = (complete && !dp_write_reg) ? mem_reg[dp_off_reg] : 32'h0;
  assign regs_o = mem_reg;

endmodule
